// File: rtl/data_memory_dumper.sv
// Snapshots the data-memory debug bus on request and streams it out one byte per
// valid/ready transfer: slot 0 first, most-significant byte of each slot first.
module data_memory_dumper #(
  parameter int unsigned ADDR_SIZE = 5,
  parameter int unsigned SLOT_SIZE = 32,
  parameter int unsigned BYTE_SIZE = 8
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset,
  input  logic                                  i_start,
  input  logic                                  i_abort,
  input  logic [(2**ADDR_SIZE)*SLOT_SIZE-1:0]   i_bus_debug,
  input  logic                                  i_tx_ready,
  output logic [BYTE_SIZE-1:0]                  o_tx_data,
  output logic                                  o_tx_valid,
  output logic                                  o_busy,
  output logic                                  o_done
);

  localparam int unsigned BusW         = (2**ADDR_SIZE) * SLOT_SIZE;
  localparam int unsigned BytesPerSlot = SLOT_SIZE / BYTE_SIZE;
  localparam int unsigned Total        = (2**ADDR_SIZE) * BytesPerSlot;
  localparam int unsigned CntW         = (Total > 1) ? $clog2(Total) : 1;

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [BusW-1:0]       snap_q, snap_d;
  logic [BYTE_SIZE-1:0]  tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Byte k lives in slot k/BytesPerSlot, counted from the slot's MSB end.
  function automatic logic [BYTE_SIZE-1:0] byte_at(input logic [BusW-1:0] bus,
                                                   input int unsigned k);
    int unsigned off;
    off = (k / BytesPerSlot) * SLOT_SIZE + (BytesPerSlot - 1 - k % BytesPerSlot) * BYTE_SIZE;
    return bus[off +: BYTE_SIZE];
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    snap_d     = snap_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          snap_d     = i_bus_debug;
          cnt_d      = '0;
          tx_data_d  = byte_at(i_bus_debug, 0);
          tx_valid_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = StSend;
        end
      end
      StSend: begin
        if (i_abort) begin
          cnt_d      = '0;
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
          state_d    = StIdle;
        end else if (i_tx_ready) begin
          if (cnt_q == CntW'(Total - 1)) begin
            cnt_d      = '0;
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            state_d    = StDone;
          end else begin
            cnt_d     = cnt_q + CntW'(1);
            tx_data_d = byte_at(snap_q, 32'(cnt_q) + 32'd1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d    = StIdle;
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      snap_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_valid = tx_valid_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_data_memory_dumper.sv
// Bench for data_memory_dumper: directed and randomized dumps checked against a
// byte-order reference computed from the snapshot value.
module tb_data_memory_dumper;

  localparam int ASz   = 2;
  localparam int SSz   = 32;
  localparam int Total = 16;
  localparam int BW    = (2**ASz) * SSz;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          ready;
  logic [BW-1:0] bus;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  data_memory_dumper #(
    .ADDR_SIZE(ASz),
    .SLOT_SIZE(SSz),
    .BYTE_SIZE(8)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_start    (start),
    .i_abort    (abort),
    .i_bus_debug(bus),
    .i_tx_ready (ready),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .o_busy     (busy),
    .o_done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: byte k = slot k/4, MSB first inside the slot.
  function automatic logic [7:0] ref_byte(input logic [BW-1:0] snap, input int k);
    logic [BW-1:0] t;
    t = snap >> ((k / 4) * SSz + (3 - k % 4) * 8);
    return t[7:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, {31'd0, tx_valid}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy},     32'd0);
    check({tag, "_done"},  {31'd0, done},     32'd0);
  endtask

  // One dump. Negative indices disable the corresponding disturbance.
  task automatic run_dump(input logic [BW-1:0] data, input bit rnd, input int stall_idx,
                          input int abort_idx, input int start_idx, input int change_cyc);
    logic [7:0] exp [Total];
    int  idx;
    int  cyc;
    int  stall;
    bit  fin;
    for (int k = 0; k < Total; k++) exp[k] = ref_byte(data, k);
    idx = 0; cyc = 0; stall = 0; fin = 0;
    bus = data;
    start = 1'b1;
    step();
    start = 1'b0;
    while (!fin && cyc < 300) begin
      check("valid",    {31'd0, tx_valid}, 32'd1);
      check("busy",     {31'd0, busy},     32'd1);
      check("done_low", {31'd0, done},     32'd0);
      check($sformatf("byte%0d", idx), {24'd0, tx_data}, {24'd0, exp[idx]});
      cyc++;
      if (cyc == change_cyc) bus = ~bus;
      ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (idx == stall_idx && stall < 3) begin
        ready = 1'b0;
        stall++;
      end
      start = (idx == start_idx);
      abort = (idx == abort_idx);
      if (abort) ready = 1'b1;
      step();
      start = 1'b0;
      if (abort) begin
        abort = 1'b0;
        check_idle("abort");
        fin = 1;
      end else if (ready) begin
        idx++;
        if (idx == Total) begin
          check("end_valid", {31'd0, tx_valid}, 32'd0);
          check("end_busy",  {31'd0, busy},     32'd0);
          check("end_done",  {31'd0, done},     32'd1);
          start = 1'b1;  // must be ignored while in DONE
          step();
          start = 1'b0;
          check_idle("post_done");
          fin = 1;
        end
      end
    end
    if (!fin) check("dump_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [BW-1:0] base;
    base  = {32'hDEADBEEF, 32'h01020304, 32'hAABBCCDD, 32'h11223344};
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    ready = 1'b0;
    bus   = '0;
    #12;
    check("rst_data", {24'd0, tx_data}, 32'd0);
    check_idle("rst");
    rst = 1'b0;
    step();
    abort = 1'b1;  // ignored in IDLE
    step();
    abort = 1'b0;
    check_idle("idle_abort");

    run_dump(base, 1'b0, -1, -1, -1, -1);  // basic
    run_dump(base, 1'b0,  2, -1, -1, -1);  // backpressure on 0x33
    run_dump(base, 1'b0, -1, -1, -1,  2);  // bus changes after capture
    run_dump(base, 1'b0, -1,  5, -1, -1);  // abort on 0xBB
    run_dump(base, 1'b0, -1, -1, -1, -1);  // restart from 0x11
    run_dump(base, 1'b0, -1, -1,  7, -1);  // start while busy

    // Asynchronous reset mid-dump
    bus = base;
    ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    check("arst_data", {24'd0, tx_data}, 32'd0);
    check_idle("arst");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_idle("arst_wait");

    for (int r = 0; r < 10; r++) begin
      logic [BW-1:0] d;
      int ab;
      d  = {$urandom, $urandom, $urandom, $urandom};
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, Total - 1)) : -1;
      run_dump(d, 1'b1, int'($urandom_range(0, Total - 1)), ab, -1,
               int'($urandom_range(1, 6)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
